// File: rtl/spi_frame_pkg.sv
// Shared definitions for the SPI frame link; the slave side imports the same
// byte-format helpers so both ends agree on how a 14-bit value is split.
package spi_frame_pkg;

    typedef enum logic [3:0] {
        IDLE,
        SETUP,
        SEND_HI,
        WAIT_HI,
        GAP,
        SEND_LO,
        WAIT_LO,
        HOLD,
        ABORT,
        RECOVER
    } sched_state_t;

    localparam int FRAME_BYTES = 2;

    function automatic logic [7:0] hi_byte(input logic [13:0] v);
        return {2'b00, v[13:8]};
    endfunction

    function automatic logic [7:0] lo_byte(input logic [13:0] v);
        return v[7:0];
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/spi_cycle_timer.sv
// Loadable down-counter shared by every timed phase of the frame scheduler;
// expired is high once the count has run down to zero.
module spi_cycle_timer #(
    parameter int WIDTH = 11
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             expired
);

    logic [WIDTH-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - WIDTH'(1);
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/spi_frame_scheduler.sv
// Frames the 14-bit counter value as two SPI bytes under slave select, with
// setup/gap/hold/recover timing, a byte timeout and a one-deep pending slot.
module spi_frame_scheduler
    import spi_frame_pkg::*;
#(
    parameter int SS_SETUP_CYC = 4,
    parameter int BYTE_GAP_CYC = 2,
    parameter int SS_HOLD_CYC  = 4,
    parameter int SS_HIGH_CYC  = 2,
    parameter int TIMEOUT_CYC  = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        send_req,
    input  logic [13:0] counter,
    output logic        spi_start,
    output logic [7:0]  spi_tx_data,
    input  logic        spi_done,
    output logic        ss,
    output logic        busy,
    output logic        frame_done,
    output logic        timeout_err,
    output logic [7:0]  overrun_cnt
);

    localparam int MAX_CYC = max_int(max_int(max_int(SS_SETUP_CYC, BYTE_GAP_CYC),
                                             max_int(SS_HOLD_CYC, SS_HIGH_CYC)),
                                     TIMEOUT_CYC);
    localparam int TMR_W = $clog2(MAX_CYC + 1);

    // Timer is loaded with N-1 so the owning state lasts exactly N cycles.
    localparam logic [TMR_W-1:0] SETUP_LOAD   = TMR_W'(SS_SETUP_CYC - 1);
    localparam logic [TMR_W-1:0] GAP_LOAD     = TMR_W'((BYTE_GAP_CYC > 0) ? BYTE_GAP_CYC - 1 : 0);
    localparam logic [TMR_W-1:0] HOLD_LOAD    = TMR_W'(SS_HOLD_CYC - 1);
    localparam logic [TMR_W-1:0] HIGH_LOAD    = TMR_W'(SS_HIGH_CYC - 1);
    localparam logic [TMR_W-1:0] TIMEOUT_LOAD = TMR_W'(TIMEOUT_CYC - 1);
    localparam bit               GAP_EN       = (BYTE_GAP_CYC > 0);

    sched_state_t     state;
    sched_state_t     next_state;
    logic             tmr_load;
    logic [TMR_W-1:0] tmr_val;
    logic             tmr_expired;

    logic [13:0]      value_reg;
    logic [13:0]      pending_reg;
    logic             pending;
    logic             recover_exit;
    logic             ss_low_next;

    spi_cycle_timer #(
        .WIDTH (TMR_W)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .expired  (tmr_expired)
    );

    assign recover_exit = (state == RECOVER) && tmr_expired;

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        next_state = state;
        tmr_load   = 1'b0;
        tmr_val    = '0;
        case (state)
            IDLE: begin
                if (send_req) begin
                    next_state = SETUP;
                    tmr_load   = 1'b1;
                    tmr_val    = SETUP_LOAD;
                end
            end
            SETUP: begin
                if (tmr_expired) begin
                    next_state = SEND_HI;
                    tmr_load   = 1'b1;
                    tmr_val    = TIMEOUT_LOAD;
                end
            end
            SEND_HI: next_state = WAIT_HI;
            WAIT_HI: begin
                // A done on the final timeout cycle still completes the byte.
                if (spi_done) begin
                    tmr_load = 1'b1;
                    if (GAP_EN) begin
                        next_state = GAP;
                        tmr_val    = GAP_LOAD;
                    end else begin
                        next_state = SEND_LO;
                        tmr_val    = TIMEOUT_LOAD;
                    end
                end else if (tmr_expired) begin
                    next_state = ABORT;
                end
            end
            GAP: begin
                if (tmr_expired) begin
                    next_state = SEND_LO;
                    tmr_load   = 1'b1;
                    tmr_val    = TIMEOUT_LOAD;
                end
            end
            SEND_LO: next_state = WAIT_LO;
            WAIT_LO: begin
                if (spi_done) begin
                    next_state = HOLD;
                    tmr_load   = 1'b1;
                    tmr_val    = HOLD_LOAD;
                end else if (tmr_expired) begin
                    next_state = ABORT;
                end
            end
            HOLD: begin
                if (tmr_expired) begin
                    next_state = RECOVER;
                    tmr_load   = 1'b1;
                    tmr_val    = HIGH_LOAD;
                end
            end
            ABORT: begin
                next_state = RECOVER;
                tmr_load   = 1'b1;
                tmr_val    = HIGH_LOAD;
            end
            RECOVER: begin
                if (tmr_expired) begin
                    if (pending || send_req) begin
                        next_state = SETUP;
                        tmr_load   = 1'b1;
                        tmr_val    = SETUP_LOAD;
                    end else begin
                        next_state = IDLE;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        ss_low_next = 1'b0;
        case (next_state)
            SETUP, SEND_HI, WAIT_HI, GAP, SEND_LO, WAIT_LO, HOLD: ss_low_next = 1'b1;
            default: ss_low_next = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            ss          <= 1'b1;
            spi_start   <= 1'b0;
            spi_tx_data <= 8'h00;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state       <= next_state;
            ss          <= !ss_low_next;
            spi_start   <= (next_state == SEND_HI) || (next_state == SEND_LO);
            busy        <= (next_state != IDLE);
            frame_done  <= (state == HOLD) && (next_state == RECOVER);
            timeout_err <= (next_state == ABORT);
            if (next_state == SEND_HI) begin
                spi_tx_data <= hi_byte(value_reg);
            end else if (next_state == SEND_LO) begin
                spi_tx_data <= lo_byte(value_reg);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            value_reg   <= '0;
            pending_reg <= '0;
            pending     <= 1'b0;
            overrun_cnt <= 8'h00;
        end else if (state == IDLE) begin
            if (send_req) begin
                value_reg <= counter;
            end
        end else if (recover_exit) begin
            // A request arriving as the slot drains refills it without overrun.
            if (pending) begin
                value_reg <= pending_reg;
                pending   <= send_req;
                if (send_req) begin
                    pending_reg <= counter;
                end
            end else if (send_req) begin
                value_reg <= counter;
            end
        end else if (send_req) begin
            pending_reg <= counter;
            pending     <= 1'b1;
            if (pending && (overrun_cnt != 8'hFF)) begin
                overrun_cnt <= overrun_cnt + 8'd1;
            end
        end
    end

endmodule
